// File: rtl/demo_enable_gen_pkg.sv
// Shared definitions for the demo enable-pulse generator: state encoding and
// default widths.
package demo_enable_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int PRESCALE_W_DEF = 16;
    localparam int BURST_W_DEF    = 8;

endpackage : demo_enable_gen_pkg

// File: rtl/demo_prescaler.sv
// Reloadable down-counter that sets the spacing between enable pulses.
// A load takes priority over a decrement. The zero flag comes straight from
// the count register.
module demo_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] pre_q;

    // Count register: reload on load, otherwise count down when asked.
    // NOTE: reset is synchronous here, so it is tested inside the clocked block
    // and is left out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (load) begin
            pre_q <= load_val;
        end else if (dec) begin
            pre_q <= pre_q - 1'b1;
        end
    end

    assign zero = (pre_q == '0);

endmodule : demo_prescaler

// File: rtl/demo_enable_gen.sv
// Programmable enable-pulse generator that drives the enable input of the
// downstream 8-bit demo counter. A run emits one-cycle pulses every div+1
// active cycles, either without end or for a fixed burst. The run can be
// paused with hold and aborted with stop.
module demo_enable_gen
    import demo_enable_gen_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BURST_W    = BURST_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] cfg_div,
    input  logic [BURST_W-1:0]    cfg_burst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    output logic                  enable,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [BURST_W-1:0]    cnt_q, cnt_d;
    logic                  enable_d, busy_d, done_d;

    logic                  pre_load;
    logic [PRESCALE_W-1:0] pre_load_val;
    logic                  pre_dec;
    logic                  pre_zero;

    demo_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .load     (pre_load),
        .load_val (pre_load_val),
        .dec      (pre_dec),
        .zero     (pre_zero)
    );

    // Next-state and output decode. A PAUSE cycle with hold low does the RUN
    // work, so each held edge costs exactly one cycle of delay.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case can leave a value unassigned and infer a latch.
        state_d      = state_q;
        div_d        = div_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        enable_d     = 1'b0;
        done_d       = 1'b0;
        pre_load     = 1'b0;
        pre_load_val = div_q;
        pre_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d      = ST_RUN;
                    div_d        = cfg_div;
                    burst_d      = cfg_burst;
                    cnt_d        = '0;
                    pre_load     = 1'b1;
                    pre_load_val = cfg_div;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (pre_zero) begin
                        enable_d = 1'b1;
                        pre_load = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        // Burst length 0 means continuous; cnt then wraps unseen.
                        if (burst_q != '0 && cnt_d == burst_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pre_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, latched configuration, pulse counter and registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            enable  <= enable_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule : demo_enable_gen

// File: tb/tb_demo_enable_gen.sv
// Scoreboard bench for demo_enable_gen. The reference model counts active
// ticks since start and fires a pulse on every (div+1)-th tick. A bench-side
// 8-bit counter stands in for the downstream demo counter.
module tb_demo_enable_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_burst;
    logic        start, stop, hold;
    logic        enable, busy, done;

    typedef struct packed {
        logic en;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    bit   m_active = 1'b0;
    int   m_div    = 0;
    int   m_burst  = 0;
    int   m_ticks  = 0;
    int   m_pulses = 0;
    int   m_ds_cnt = 0;

    // Downstream demo counter, fed from the DUT enable.
    logic       ds_clr = 1'b0;
    logic [7:0] ds_cnt;

    demo_enable_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ds_clr)      ds_cnt <= 8'd0;
        else if (enable) ds_cnt <= ds_cnt + 8'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("enable", int'(enable), int'(e.en));
            check("busy",   int'(busy),   int'(e.busy));
            check("done",   int'(done),   int'(e.done));
        end
    end

    // Model for one clock edge, given the inputs that edge samples.
    function automatic exp_t model_step(bit rst, bit st, bit sp, bit hd, int dv, int bu);
        exp_t e;
        e = '0;
        if (rst) begin
            m_active = 1'b0;
            m_div    = 0;
            m_burst  = 0;
            m_ticks  = 0;
            m_pulses = 0;
        end else if (!m_active) begin
            if (st && !sp) begin
                m_active = 1'b1;
                m_div    = dv;
                m_burst  = bu;
                m_ticks  = 0;
                m_pulses = 0;
            end
        end else if (sp) begin
            m_active = 1'b0;
        end else if (!hd) begin
            m_ticks++;
            if (m_ticks % (m_div + 1) == 0) begin
                e.en = 1'b1;
                m_pulses++;
                if (m_burst != 0 && m_pulses == m_burst) begin
                    e.done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        e.busy = m_active;
        return e;
    endfunction

    // Drive one cycle of inputs, predict the outcome, then advance one edge.
    task automatic cycle(input bit rst, input bit st, input bit sp, input bit hd,
                         input int dv, input int bu);
        exp_t e;
        reset     = rst;
        start     = st;
        stop      = sp;
        hold      = hd;
        cfg_div   = 16'(dv);
        cfg_burst = 8'(bu);
        e = model_step(rst, st, sp, hd, dv, bu);
        if (ds_clr)    m_ds_cnt = 0;
        else if (e.en) m_ds_cnt = (m_ds_cnt + 1) % 256;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int dv, input int bu);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, dv, bu);
    endtask

    initial begin
        // Reset, including the downstream counter.
        ds_clr = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        ds_clr = 1'b0;
        idle(2, 0, 0);

        // Reset mid-run, then no pulses until a new start.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        idle(9, 3, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        idle(12, 3, 0);

        // Burst of 4 with div 2, then an immediate restart after done.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 4);
        idle(11, 2, 4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        idle(4, 0, 0);

        // Continuous, div 0, stop five cycles later.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(4, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(4, 0, 0);

        // Hold for three edges starting when two ticks remain.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4, 2);
        idle(2, 4, 2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 4, 2);
        idle(14, 4, 2);

        // Start with stop in IDLE, then a start during RUN with another div.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2, 3);
        idle(2, 2, 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 3);
        idle(2, 2, 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 7, 9);
        idle(10, 7, 9);

        // Closed loop with the downstream counter: 255 pulses, then 2 more.
        ds_clr = 1'b1;
        idle(1, 0, 0);
        ds_clr = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 255);
        idle(515, 1, 255);
        check("ds_cnt_after_255", int'(ds_cnt), m_ds_cnt);
        check("ds_cnt_is_255", int'(ds_cnt), 255);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 2);
        idle(8, 1, 2);
        check("ds_cnt_wrap", int'(ds_cnt), m_ds_cnt);
        check("ds_cnt_is_1", int'(ds_cnt), 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 6)));
        end
        idle(2, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demo_enable_gen
